// File: rtl/auth_pkg.sv
// Shared constants, codes and state encoding for the USB Type-C authentication responder.
package auth_pkg;

    localparam int HDR_BYTE_W = 8;
    localparam int HDR_LEN    = 4;
    localparam int HDR_W      = HDR_BYTE_W * HDR_LEN;

    localparam logic [7:0] PROTO_VER = 8'h01;

    // Request message types
    localparam logic [7:0] MT_GET_DIGESTS = 8'h81;
    localparam logic [7:0] MT_GET_CERT    = 8'h82;
    localparam logic [7:0] MT_CHALLENGE   = 8'h83;

    // Response types
    localparam logic [7:0] RT_DIGESTS   = 8'h01;
    localparam logic [7:0] RT_CERT      = 8'h02;
    localparam logic [7:0] RT_CHALLENGE = 8'h03;
    localparam logic [7:0] RT_ERROR     = 8'h7F;
    localparam logic [7:0] RT_MASK      = 8'h7F;

    // ERROR response codes
    localparam logic [7:0] ERR_INVALID     = 8'h01;
    localparam logic [7:0] ERR_UNSUP_PROTO = 8'h02;
    localparam logic [7:0] ERR_BUSY        = 8'h03;
    localparam logic [7:0] ERR_UNSPEC      = 8'h04;

    // USB control-transfer setup fields
    localparam logic [7:0]  BMRT_DEV_TO_HOST = 8'h80;
    localparam logic [7:0]  BMRT_HOST_TO_DEV = 8'h00;
    localparam logic [7:0]  BREQ_AUTH_IN     = 8'd24;
    localparam logic [7:0]  BREQ_AUTH_OUT    = 8'd25;
    localparam logic [15:0] WLEN_DIGESTS     = 16'd260;
    localparam logic [15:0] WLEN_CHALLENGE   = 16'd32;
    localparam logic [15:0] WLEN_ERROR       = 16'd4;

    typedef enum logic [1:0] {
        SEL_NONE      = 2'd0,
        SEL_DIGESTS   = 2'd1,
        SEL_CERT      = 2'd2,
        SEL_CHALLENGE = 2'd3
    } gen_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_START,
        ST_WAIT,
        ST_SEND
    } state_e;

    function automatic logic [HDR_W-1:0] err_header(input logic [7:0] code);
        return {PROTO_VER, RT_ERROR, code, 8'h00};
    endfunction

endpackage

// File: rtl/auth_hdr_classify.sv
// Combinational request-header decode: generator selection, slot check and error priority.
module auth_hdr_classify
    import auth_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic [7:0]           proto_ver,
    input  logic [7:0]           msg_type,
    input  logic [7:0]           param1,
    input  logic                 busy,
    input  logic [NUM_SLOTS-1:0] slot_mask,
    output logic                 err_valid,
    output logic [7:0]           err_code,
    output logic [1:0]           gen_sel
);

    // Widen the mask so any 8-bit slot index is a legal bit select.
    logic [255:0] mask_ext;
    logic         slot_ok;

    assign mask_ext = 256'(slot_mask);
    assign slot_ok  = ({1'b0, param1} < 9'(NUM_SLOTS)) && mask_ext[param1];

    always_comb begin
        gen_sel = SEL_NONE;
        case (msg_type)
            MT_GET_DIGESTS: gen_sel = SEL_DIGESTS;
            MT_GET_CERT:    gen_sel = SEL_CERT;
            MT_CHALLENGE:   gen_sel = SEL_CHALLENGE;
            default:        gen_sel = SEL_NONE;
        endcase

        err_valid = 1'b1;
        err_code  = ERR_INVALID;
        if (busy) begin
            err_code = ERR_BUSY;
        end else if (proto_ver != PROTO_VER) begin
            err_code = ERR_UNSUP_PROTO;
        end else if (gen_sel == SEL_NONE) begin
            err_code = ERR_INVALID;
        end else if (gen_sel != SEL_DIGESTS && !slot_ok) begin
            err_code = ERR_INVALID;
        end else begin
            err_valid = 1'b0;
            err_code  = 8'h00;
        end
    end

endmodule

// File: rtl/auth_responder_mc.sv
// Authentication responder: request decode, answer-generator handshake, response hold.
// Optional AUTH_RESP_TIMEOUT_EN adds the generator timeout counter and Unspecified error.
module auth_responder_mc
    import auth_pkg::*;
#(
    parameter int MSG_LEN    = 1024,
    parameter int NUM_SLOTS  = 8,
    parameter int TIMEOUT_W  = 32,
    parameter int DIGEST_TMO = 1000,
    parameter int CERT_TMO   = 1000,
    parameter int CHAL_TMO   = 2000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MSG_LEN-1:0]       req_msg,
    input  logic                     busy_in,
    input  logic [NUM_SLOTS-1:0]     slot_mask,
    output logic                     gen_start,
    output logic [1:0]               gen_sel,
    input  logic                     gen_done,
    input  logic                     gen_err,
    input  logic [MSG_LEN-HDR_W-1:0] gen_payload,
    input  logic [15:0]              gen_wlength,
    output logic                     rsp_valid,
    input  logic                     rsp_ack,
    output logic [HDR_W-1:0]         rsp_header,
    output logic [MSG_LEN-HDR_W-1:0] rsp_payload,
    output logic [7:0]               bmRequestType,
    output logic [7:0]               bRequest,
    output logic [15:0]              wLength,
    output logic [TIMEOUT_W-1:0]     current_timeout
);

    localparam int PL_W = MSG_LEN - HDR_W;

    state_e               state_q, state_d;
    logic                 req_ready_q, req_ready_d;
    logic [7:0]           pver_q, pver_d, mtype_q, mtype_d, p1_q, p1_d, p2_q, p2_d;
    logic                 gen_start_q, gen_start_d;
    logic [1:0]           gen_sel_q, gen_sel_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [HDR_W-1:0]     rsp_header_q, rsp_header_d;
    logic [PL_W-1:0]      rsp_payload_q, rsp_payload_d;
    logic [7:0]           bm_q, bm_d, breq_q, breq_d;
    logic [15:0]          wlen_q, wlen_d;
    logic [TIMEOUT_W-1:0] cur_tmo_q, cur_tmo_d;

    logic                 cls_err_valid;
    logic [7:0]           cls_err_code;
    logic [1:0]           cls_gen_sel;
    logic                 load_err, load_ok, tmo_hit;
    logic [7:0]           resp_code;
    logic                 unused_msg;

    assign unused_msg = ^req_msg[PL_W-1:0];

    auth_hdr_classify #(.NUM_SLOTS(NUM_SLOTS)) u_classify (
        .proto_ver (pver_q),
        .msg_type  (mtype_q),
        .param1    (p1_q),
        .busy      (busy_in),
        .slot_mask (slot_mask),
        .err_valid (cls_err_valid),
        .err_code  (cls_err_code),
        .gen_sel   (cls_gen_sel)
    );

    function automatic logic [TIMEOUT_W-1:0] sel_timeout(input logic [1:0] sel);
        case (sel)
            SEL_DIGESTS:   return TIMEOUT_W'(DIGEST_TMO);
            SEL_CERT:      return TIMEOUT_W'(CERT_TMO);
            SEL_CHALLENGE: return TIMEOUT_W'(CHAL_TMO);
            default:       return '0;
        endcase
    endfunction

`ifdef AUTH_RESP_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is 0 in the first WAIT cycle, so hitting TMO-1 exits after TMO WAIT cycles.
    assign tmo_hit = (tmo_cnt_q == cur_tmo_q - TIMEOUT_W'(1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_START)
            tmo_cnt_d = '0;
        else if (state_q == ST_WAIT)
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        pver_d        = pver_q;
        mtype_d       = mtype_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        gen_start_d   = 1'b0;
        gen_sel_d     = gen_sel_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_header_d  = rsp_header_q;
        rsp_payload_d = rsp_payload_q;
        bm_d          = bm_q;
        breq_d        = breq_q;
        wlen_d        = wlen_q;
        cur_tmo_d     = cur_tmo_q;
        load_err      = 1'b0;
        load_ok       = 1'b0;
        resp_code     = 8'h00;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    {pver_d, mtype_d, p1_d, p2_d} = req_msg[MSG_LEN-1 -: HDR_W];
                    req_ready_d = 1'b0;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cls_err_valid) begin
                    load_err  = 1'b1;
                    resp_code = cls_err_code;
                    cur_tmo_d = '0;
                end else begin
                    gen_start_d = 1'b1;
                    gen_sel_d   = cls_gen_sel;
                    cur_tmo_d   = sel_timeout(cls_gen_sel);
                    state_d     = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (gen_err) begin
                    load_err  = 1'b1;
                    resp_code = ERR_INVALID;
                end else if (gen_done) begin
                    load_ok = 1'b1;
                end else if (tmo_hit) begin
                    load_err  = 1'b1;
                    resp_code = ERR_UNSPEC;
                end
            end
            ST_SEND: begin
                if (rsp_ack) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_err) begin
            rsp_header_d  = err_header(resp_code);
            rsp_payload_d = '0;
            bm_d          = BMRT_DEV_TO_HOST;
            breq_d        = BREQ_AUTH_IN;
            wlen_d        = WLEN_ERROR;
        end
        if (load_ok) begin
            rsp_header_d  = {pver_q, mtype_q & RT_MASK, p1_q, p2_q};
            rsp_payload_d = gen_payload;
            case (gen_sel_q)
                SEL_DIGESTS: begin
                    bm_d = BMRT_DEV_TO_HOST; breq_d = BREQ_AUTH_IN;  wlen_d = WLEN_DIGESTS;
                end
                SEL_CERT: begin
                    bm_d = BMRT_HOST_TO_DEV; breq_d = BREQ_AUTH_OUT; wlen_d = gen_wlength;
                end
                default: begin
                    bm_d = BMRT_HOST_TO_DEV; breq_d = BREQ_AUTH_OUT; wlen_d = WLEN_CHALLENGE;
                end
            endcase
        end
        if (load_err || load_ok) begin
            rsp_valid_d = 1'b1;
            gen_sel_d   = SEL_NONE;
            state_d     = ST_SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            pver_q        <= '0;
            mtype_q       <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            gen_start_q   <= 1'b0;
            gen_sel_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_header_q  <= '0;
            rsp_payload_q <= '0;
            bm_q          <= '0;
            breq_q        <= '0;
            wlen_q        <= '0;
            cur_tmo_q     <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            pver_q        <= pver_d;
            mtype_q       <= mtype_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            gen_start_q   <= gen_start_d;
            gen_sel_q     <= gen_sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_header_q  <= rsp_header_d;
            rsp_payload_q <= rsp_payload_d;
            bm_q          <= bm_d;
            breq_q        <= breq_d;
            wlen_q        <= wlen_d;
            cur_tmo_q     <= cur_tmo_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign gen_start       = gen_start_q;
    assign gen_sel         = gen_sel_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_header      = rsp_header_q;
    assign rsp_payload     = rsp_payload_q;
    assign bmRequestType   = bm_q;
    assign bRequest        = breq_q;
    assign wLength         = wlen_q;
    assign current_timeout = cur_tmo_q;

endmodule
